control_unit_fsm: RTL and testbench
===================================

// Module: control_unit_fsm
// PURPOSE
//  Moore FSM that sequences the single-bus datapath: instruction fetch, decode and per-class execute steps.
//  Drives every datapath strobe, including register-file select and ALU op, from the current IR.
//  Adds wait-state handshakes to external memory and supports halt/stop.
//  Sits beside the datapath; its outputs connect 1:1 to the datapath control inputs.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting on mem_ready per access; 0 = wait forever
// PORTS
//  clock        in   1   system clock; all state changes on rising edge
//  clear        in   1   asynchronous active-high reset
//  ir           in   32  IR contents; opcode = ir[31:27]
//  mem_ready    in   1   memory completes Read/Write this cycle
//  stop         in   1   level; halt at next instruction boundary
//  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout  out 1  bus drivers
//  MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable  out 1  register loads
//  Z_low_enable, Z_high_enable, HI_enable, LO_enable  out 1  register loads
//  IncPC, Read, Write  out 1  PC increment, memory strobes
//  GRA, GRB, GRC, Rin, Rout, BAout  out 1  IR register-select controls
//  operation    out  5   ALU opcode
//  run          out  1   1 while executing; 0 in HALT
//  fault        out  1   sticky; memory timeout
//  illegal      out  1   1-cycle pulse in DECODE on an undefined opcode
//  instr_done   out  1   1-cycle pulse in the last step of each instruction
// BEHAVIOUR
//  - Outputs are a pure decode of the state register. clear -> state RST; every output 0; fault 0.
//  - RST (all outputs 0) -> T0 next cycle. run=1 in every state except RST/HALT.
//  - T0: PCout, MAR_enable, IncPC.
//  - T1: Read, MDR_enable. Holds until mem_ready=1.
//  - T2: MDRout, IR_enable.
//  - T3 = DECODE.
//  - Execute steps; the listed actions begin in DECODE:
//    ALU-R 03-0B (rA<-rB op rC): GRB,Rout,Y_enable | GRC,Rout,operation=opcode,Z_low_enable | ZLowout,GRA,Rin.
//    ALU-I 0C addi/0D andi/0E ori: GRB,Rout,Y_enable | Cout,operation=ADD/AND/OR,Z_low_enable | ZLowout,GRA,Rin.
//    ld 00: GRB,BAout,Y_enable | Cout,ADD,Z_low_enable | ZLowout,MAR_enable | Read,MDR_enable(wait) | MDRout,GRA,Rin.
//    st 02: the first three steps of ld | GRA,Rout,MDR_enable | Write (wait on mem_ready).
//    mul 0F/div 10: GRA,Rout,Y_enable | GRB,Rout,operation=opcode,Z_low_enable,Z_high_enable | ZLowout,LO_enable | ZHighout,HI_enable.
//    mfhi 17 / mflo 18: HIout or LOout, GRA, Rin (single step).
//    nop 19: single idle step.
//    halt 1A: -> HALT.
//    Undefined opcodes: illegal=1, then behave as nop.
//  - Wait states: the state and its strobes persist until mem_ready=1. An internal counter resets on entry to each wait state.
//    If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT without mem_ready: fault<=1, -> HALT.
//  - Instruction boundary: the last execute step asserts instr_done, then goes -> T0, or -> HALT if stop=1 at that edge.
//    stop never aborts an instruction mid-flight.
//  - HALT: all strobes 0, run=0. Left only by clear.
//  - clear mid-instruction aborts immediately. Partial register writes already clocked remain.
//  - At most one bus driver is asserted in any state; PC_enable is never asserted (reserved for branch extension).
// CONFIGURATION
//  CU_SINGLE_STEP_EN defined: adds input step (1 bit).
//    Every transition into T0, including from RST, instead enters STEP_WAIT (outputs 0, run=1).
//    STEP_WAIT -> T0 on a cycle with step=1. stop=1 in STEP_WAIT -> HALT.
//  Undefined: no step port, no STEP_WAIT; boundaries go straight to T0.
// STRUCTURE
//  Package cu_pkg:
//    - 5-bit opcode localparams (OP_LD..OP_HALT).
//    - ALU op constants ALU_ADD/ALU_AND/ALU_OR.
//    - State enum.
//    - Instruction-class enum {CL_ALU_R, CL_ALU_I, CL_LD, CL_ST, CL_MULDIV, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL}.
//  Sub-module cu_opcode_decode: combinational opcode -> class plus ALU op. The FSM stays in control_unit_fsm.
// TESTING
//  1. clear=1, then released: first cycle all outputs 0; next cycle PCout=MAR_enable=IncPC=1; run=1.
//  2. Fetch with mem_ready low 3 cycles: Read held 4 cycles; IR_enable one cycle after mem_ready.
//  3. ir=add r1,r2,r3: DECODE GRB+Rout+Y_enable; then GRC+Rout+Z_low_enable with operation=5'h03; then ZLowout+GRA+Rin with instr_done.
//  4. ir=ld r4,8(r2), mem_ready after 2 cycles: exact 7-step ld sequence (BAout in DECODE, MDRout+Rin last).
//  5. MEM_TIMEOUT=4, mem_ready held 0 during fetch: fault=1, run=0 after 4 wait cycles; stays until clear.
//  6. stop=1 during a mul: all 4 mul steps complete, HI_enable last, then HALT. Opcode 5'h1F: illegal pulse, next state T0.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// Shared opcodes, ALU op codes, FSM states and instruction classes for control_unit_fsm.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_ROL  = 5'h0B;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_ANDI = 5'h0D;
    localparam logic [4:0] OP_ORI  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_MFHI = 5'h17;
    localparam logic [4:0] OP_MFLO = 5'h18;
    localparam logic [4:0] OP_NOP  = 5'h19;
    localparam logic [4:0] OP_HALT = 5'h1A;

    localparam logic [4:0] ALU_ADD = 5'h03;
    localparam logic [4:0] ALU_AND = 5'h05;
    localparam logic [4:0] ALU_OR  = 5'h06;

    // T3 is DECODE; T4..T7 are the execute steps that follow it
    typedef enum logic [3:0] {
        S_RST, S_STEP_WAIT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } cu_state_t;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_LD, CL_ST, CL_MULDIV,
        CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
    } cu_class_t;

endpackage

// File: rtl/control_unit_fsm_if.sv
// Control-unit <-> datapath/memory bundle; the step input exists only with CU_SINGLE_STEP_EN.
interface control_unit_fsm_if;

    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
`ifdef CU_SINGLE_STEP_EN
    logic        step;
`endif
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    logic MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable;
    logic Z_low_enable, Z_high_enable, HI_enable, LO_enable;
    logic IncPC, Read, Write;
    logic GRA, GRB, GRC, Rin, Rout, BAout;
    logic [4:0] operation;
    logic run, fault, illegal, instr_done;

    modport master (
        input  ir, mem_ready, stop,
`ifdef CU_SINGLE_STEP_EN
        input  step,
`endif
        output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable,
        output Z_low_enable, Z_high_enable, HI_enable, LO_enable,
        output IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout,
        output operation, run, fault, illegal, instr_done
    );

    modport slave (
        output ir, mem_ready, stop,
`ifdef CU_SINGLE_STEP_EN
        output step,
`endif
        input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable,
        input  Z_low_enable, Z_high_enable, HI_enable, LO_enable,
        input  IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout,
        input  operation, run, fault, illegal, instr_done
    );

endinterface

// File: rtl/control_unit_fsm_decode.sv
// Combinational opcode classifier: instruction class plus the ALU op used in its Z-load step.
module cu_opcode_decode
    import cu_pkg::*;
(
    input  logic [4:0] i_opcode,
    output cu_class_t  o_class,
    output logic [4:0] o_aluOp
);

    always_comb begin
        o_class = CL_ILL;
        o_aluOp = '0;
        if (i_opcode >= OP_ADD && i_opcode <= OP_ROL) begin
            o_class = CL_ALU_R;
            o_aluOp = i_opcode;
        end else begin
            case (i_opcode)
                OP_LD:   begin o_class = CL_LD;     o_aluOp = ALU_ADD;  end
                OP_ST:   begin o_class = CL_ST;     o_aluOp = ALU_ADD;  end
                OP_ADDI: begin o_class = CL_ALU_I;  o_aluOp = ALU_ADD;  end
                OP_ANDI: begin o_class = CL_ALU_I;  o_aluOp = ALU_AND;  end
                OP_ORI:  begin o_class = CL_ALU_I;  o_aluOp = ALU_OR;   end
                OP_MUL,
                OP_DIV:  begin o_class = CL_MULDIV; o_aluOp = i_opcode; end
                OP_MFHI: o_class = CL_MFHI;
                OP_MFLO: o_class = CL_MFLO;
                OP_NOP:  o_class = CL_NOP;
                OP_HALT: o_class = CL_HALT;
                default: o_class = CL_ILL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Moore control FSM for the single-bus datapath: fetch, decode, execute, memory wait states, halt.
// Optional single-step gate at instruction boundaries is enabled by defining CU_SINGLE_STEP_EN.
module control_unit_fsm
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic               clock,
    input logic               clear,
    control_unit_fsm_if.master bus
);

    cu_state_t  r_state;
    logic [15:0] r_waitCnt;
    logic        r_fault;

    cu_class_t  w_class;
    logic [4:0] w_aluOp;
    cu_state_t  w_startState;
    cu_state_t  w_boundaryState;
    logic       w_inWait;

    cu_opcode_decode u_decode (
        .i_opcode (bus.ir[31:27]),
        .o_class  (w_class),
        .o_aluOp  (w_aluOp)
    );

`ifdef CU_SINGLE_STEP_EN
    assign w_startState = S_STEP_WAIT;
`else
    assign w_startState = S_T0;
`endif

    assign w_boundaryState = bus.stop ? S_HALT : w_startState;
    assign w_inWait = (r_state == S_T1)
                    || (r_state == S_T6 && w_class == CL_LD)
                    || (r_state == S_T7 && w_class == CL_ST);
    assign bus.fault = r_fault;

    // Wait counter is cleared on every cycle that does not stay in a wait state, so it restarts per access
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state   <= S_RST;
            r_waitCnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_waitCnt <= '0;
            if (w_inWait && !bus.mem_ready) begin
                if (MEM_TIMEOUT != 0 && int'(r_waitCnt) == MEM_TIMEOUT - 1) begin
                    r_fault <= 1'b1;
                    r_state <= S_HALT;
                end else begin
                    r_waitCnt <= r_waitCnt + 16'd1;
                end
            end else begin
                case (r_state)
                    S_RST: r_state <= w_startState;
`ifdef CU_SINGLE_STEP_EN
                    S_STEP_WAIT: begin
                        if (bus.stop)      r_state <= S_HALT;
                        else if (bus.step) r_state <= S_T0;
                    end
`endif
                    S_T0: r_state <= S_T1;
                    S_T1: r_state <= S_T2;
                    S_T2: r_state <= S_T3;
                    S_T3: begin
                        case (w_class)
                            CL_ALU_R, CL_ALU_I, CL_LD, CL_ST, CL_MULDIV: r_state <= S_T4;
                            CL_HALT: r_state <= S_HALT;
                            default: r_state <= w_boundaryState;
                        endcase
                    end
                    S_T4: r_state <= S_T5;
                    S_T5: begin
                        if (w_class == CL_ALU_R || w_class == CL_ALU_I) r_state <= w_boundaryState;
                        else                                            r_state <= S_T6;
                    end
                    S_T6: begin
                        if (w_class == CL_MULDIV) r_state <= w_boundaryState;
                        else                      r_state <= S_T7;
                    end
                    S_T7: r_state <= w_boundaryState;
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    // Store's final Write step is a wait state, so its done pulse is qualified by mem_ready
    always_comb begin
        bus.PCout = 1'b0;  bus.ZLowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.HIout = 1'b0;  bus.LOout = 1'b0;   bus.Cout = 1'b0;     bus.InPortout = 1'b0;
        bus.MAR_enable = 1'b0; bus.MDR_enable = 1'b0; bus.IR_enable = 1'b0;
        bus.Y_enable = 1'b0;   bus.PC_enable = 1'b0;
        bus.Z_low_enable = 1'b0; bus.Z_high_enable = 1'b0;
        bus.HI_enable = 1'b0;    bus.LO_enable = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        bus.GRA = 1'b0; bus.GRB = 1'b0; bus.GRC = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.operation = '0;
        bus.illegal = 1'b0;
        bus.instr_done = 1'b0;
        bus.run = (r_state != S_RST) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; end
            S_T1: begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IR_enable = 1'b1; end
            S_T3: begin
                case (w_class)
                    CL_ALU_R, CL_ALU_I: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
                    CL_LD, CL_ST:       begin bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
                    CL_MULDIV:          begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
                    CL_MFHI: begin bus.HIout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; bus.instr_done = 1'b1; end
                    CL_MFLO: begin bus.LOout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; bus.instr_done = 1'b1; end
                    CL_ILL:  begin bus.illegal = 1'b1; bus.instr_done = 1'b1; end
                    default: bus.instr_done = 1'b1;
                endcase
            end
            S_T4: begin
                bus.operation = w_aluOp;
                bus.Z_low_enable = 1'b1;
                case (w_class)
                    CL_ALU_R:  begin bus.GRC = 1'b1; bus.Rout = 1'b1; end
                    CL_MULDIV: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Z_high_enable = 1'b1; end
                    default:   bus.Cout = 1'b1;
                endcase
            end
            S_T5: begin
                bus.ZLowout = 1'b1;
                case (w_class)
                    CL_LD, CL_ST: bus.MAR_enable = 1'b1;
                    CL_MULDIV:    bus.LO_enable = 1'b1;
                    default: begin bus.GRA = 1'b1; bus.Rin = 1'b1; bus.instr_done = 1'b1; end
                endcase
            end
            S_T6: begin
                case (w_class)
                    CL_LD: begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
                    CL_ST: begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.MDR_enable = 1'b1; end
                    default: begin bus.ZHighout = 1'b1; bus.HI_enable = 1'b1; bus.instr_done = 1'b1; end
                endcase
            end
            S_T7: begin
                if (w_class == CL_ST) begin
                    bus.Write = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end else begin
                    bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; bus.instr_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Table-driven, scoreboarded bench for control_unit_fsm (default build, MEM_TIMEOUT=4).
module tb_control_unit_fsm;

    typedef logic [34:0] ctl_t;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        mr;
        logic        stp;
        ctl_t        exp;
    } vec_t;

    localparam ctl_t B_PCOUT   = ctl_t'(1) << 34;
    localparam ctl_t B_ZLOWOUT = ctl_t'(1) << 33;
    localparam ctl_t B_ZHIOUT  = ctl_t'(1) << 32;
    localparam ctl_t B_MDROUT  = ctl_t'(1) << 31;
    localparam ctl_t B_HIOUT   = ctl_t'(1) << 30;
    localparam ctl_t B_MAREN   = ctl_t'(1) << 26;
    localparam ctl_t B_MDREN   = ctl_t'(1) << 25;
    localparam ctl_t B_IREN    = ctl_t'(1) << 24;
    localparam ctl_t B_YEN     = ctl_t'(1) << 23;
    localparam ctl_t B_ZLEN    = ctl_t'(1) << 21;
    localparam ctl_t B_ZHEN    = ctl_t'(1) << 20;
    localparam ctl_t B_HIEN    = ctl_t'(1) << 19;
    localparam ctl_t B_LOEN    = ctl_t'(1) << 18;
    localparam ctl_t B_INCPC   = ctl_t'(1) << 17;
    localparam ctl_t B_READ    = ctl_t'(1) << 16;
    localparam ctl_t B_WRITE   = ctl_t'(1) << 15;
    localparam ctl_t B_GRA     = ctl_t'(1) << 14;
    localparam ctl_t B_GRB     = ctl_t'(1) << 13;
    localparam ctl_t B_GRC     = ctl_t'(1) << 12;
    localparam ctl_t B_RIN     = ctl_t'(1) << 11;
    localparam ctl_t B_ROUT    = ctl_t'(1) << 10;
    localparam ctl_t B_BAOUT   = ctl_t'(1) << 9;
    localparam ctl_t B_COUT    = ctl_t'(1) << 28;
    localparam ctl_t B_RUN     = ctl_t'(1) << 3;
    localparam ctl_t B_FAULT   = ctl_t'(1) << 2;
    localparam ctl_t B_ILL     = ctl_t'(1) << 1;
    localparam ctl_t B_DONE    = ctl_t'(1) << 0;

    localparam ctl_t F0 = B_PCOUT | B_MAREN | B_INCPC | B_RUN;
    localparam ctl_t F1 = B_READ | B_MDREN | B_RUN;
    localparam ctl_t F2 = B_MDROUT | B_IREN | B_RUN;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ctl_t  expQ[$];
    string nameQ[$];
    vec_t  vecs[$];

    control_unit_fsm_if bus();

    control_unit_fsm #(.MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

`ifdef CU_SINGLE_STEP_EN
    initial bus.step = 1'b1;
`endif

    always #5 clock = ~clock;

    function automatic ctl_t opField(input logic [4:0] op);
        return ctl_t'(op) << 4;
    endfunction

    function automatic ctl_t sampleOutputs();
        return {bus.PCout, bus.ZLowout, bus.ZHighout, bus.MDRout, bus.HIout, bus.LOout,
                bus.Cout, bus.InPortout, bus.MAR_enable, bus.MDR_enable, bus.IR_enable,
                bus.Y_enable, bus.PC_enable, bus.Z_low_enable, bus.Z_high_enable,
                bus.HI_enable, bus.LO_enable, bus.IncPC, bus.Read, bus.Write,
                bus.GRA, bus.GRB, bus.GRC, bus.Rin, bus.Rout, bus.BAout,
                bus.operation, bus.run, bus.fault, bus.illegal, bus.instr_done};
    endfunction

    function automatic void addRow(input logic clr, input logic [31:0] irv, input logic mr,
                                   input logic stp, input ctl_t exp);
        vecs.push_back('{clr, irv, mr, stp, exp});
    endfunction

    // Fetch: T0, 'waits' cycles of T1 without mem_ready, one T1 with it, then T2
    function automatic void addFetch(input logic [31:0] irv, input int waits, input logic stp);
        addRow(1'b0, irv, 1'b0, stp, F0);
        for (int i = 0; i < waits; i++) addRow(1'b0, irv, 1'b0, stp, F1);
        addRow(1'b0, irv, 1'b1, stp, F1);
        addRow(1'b0, irv, 1'b0, stp, F2);
    endfunction

    // Drive one cycle's inputs away from the rising edge and queue what the DUT must show
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clock);
        clear         = v.clr;
        bus.ir        = v.ir;
        bus.mem_ready = v.mr;
        bus.stop      = v.stp;
        expQ.push_back(v.exp);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput();
        ctl_t  act;
        ctl_t  exp;
        string name;
        #1;
        act = sampleOutputs();
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: actual=%h required=queued expectation", act);
        end else begin
            exp  = expQ.pop_front();
            name = nameQ.pop_front();
            if (act !== exp) begin
                failures++;
                $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
            end
        end
    endtask

    task automatic runRow(input logic clr, input logic [31:0] irv, input logic mr,
                          input logic stp, input ctl_t exp, input string name);
        vec_t v;
        v = '{clr, irv, mr, stp, exp};
        applyStimulus(v, name);
        checkOutput();
    endtask

    initial begin
        logic [31:0] irAdd, irLd, irIll, irMul, irMfhi, irHalt, irSt;
        irAdd  = {5'h03, 4'd1, 4'd2, 4'd3, 15'd0};
        irLd   = {5'h00, 4'd4, 4'd2, 19'd8};
        irIll  = {5'h1F, 27'd0};
        irMul  = {5'h0F, 4'd5, 4'd6, 19'd0};
        irMfhi = {5'h17, 4'd7, 23'd0};
        irHalt = {5'h1A, 27'd0};
        irSt   = {5'h02, 4'd5, 4'd6, 19'd4};

        bus.ir = '0; bus.mem_ready = 1'b0; bus.stop = 1'b0;

        addRow(1'b1, irAdd, 1'b0, 1'b0, '0);
        addRow(1'b0, irAdd, 1'b0, 1'b0, '0);
        addFetch(irAdd, 3, 1'b0);
        addRow(1'b0, irAdd, 1'b0, 1'b0, B_GRB | B_ROUT | B_YEN | B_RUN);
        addRow(1'b0, irAdd, 1'b0, 1'b0, B_GRC | B_ROUT | B_ZLEN | opField(5'h03) | B_RUN);
        addRow(1'b0, irAdd, 1'b0, 1'b0, B_ZLOWOUT | B_GRA | B_RIN | B_RUN | B_DONE);

        addFetch(irLd, 0, 1'b0);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YEN | B_RUN);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_COUT | B_ZLEN | opField(5'h03) | B_RUN);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_ZLOWOUT | B_MAREN | B_RUN);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_READ | B_MDREN | B_RUN);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_READ | B_MDREN | B_RUN);
        addRow(1'b0, irLd, 1'b1, 1'b0, B_READ | B_MDREN | B_RUN);
        addRow(1'b0, irLd, 1'b0, 1'b0, B_MDROUT | B_GRA | B_RIN | B_RUN | B_DONE);

        addFetch(irIll, 0, 1'b0);
        addRow(1'b0, irIll, 1'b0, 1'b0, B_ILL | B_DONE | B_RUN);

        addFetch(irMul, 0, 1'b1);
        addRow(1'b0, irMul, 1'b0, 1'b1, B_GRA | B_ROUT | B_YEN | B_RUN);
        addRow(1'b0, irMul, 1'b0, 1'b1, B_GRB | B_ROUT | B_ZLEN | B_ZHEN | opField(5'h0F) | B_RUN);
        addRow(1'b0, irMul, 1'b0, 1'b1, B_ZLOWOUT | B_LOEN | B_RUN);
        addRow(1'b0, irMul, 1'b0, 1'b1, B_ZHIOUT | B_HIEN | B_DONE | B_RUN);
        addRow(1'b0, irMul, 1'b0, 1'b0, '0);
        addRow(1'b0, irMul, 1'b1, 1'b0, '0);

        addRow(1'b1, irAdd, 1'b0, 1'b0, '0);
        addRow(1'b0, irAdd, 1'b0, 1'b0, '0);
        addRow(1'b0, irAdd, 1'b0, 1'b0, F0);
        for (int i = 0; i < 4; i++) addRow(1'b0, irAdd, 1'b0, 1'b0, F1);
        addRow(1'b0, irAdd, 1'b0, 1'b0, B_FAULT);
        addRow(1'b0, irAdd, 1'b1, 1'b0, B_FAULT);

        addRow(1'b1, irMfhi, 1'b0, 1'b0, '0);
        addRow(1'b0, irMfhi, 1'b0, 1'b0, '0);
        addFetch(irMfhi, 0, 1'b0);
        addRow(1'b0, irMfhi, 1'b0, 1'b0, B_HIOUT | B_GRA | B_RIN | B_DONE | B_RUN);
        addFetch(irHalt, 1, 1'b0);
        addRow(1'b0, irHalt, 1'b0, 1'b0, B_DONE | B_RUN);
        addRow(1'b0, irHalt, 1'b0, 1'b0, '0);
        addRow(1'b0, irHalt, 1'b1, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("row%0d", i));
            checkOutput();
        end

        // Store: Write waits on mem_ready, done only on the completing cycle; then abort a fetch by clear
        runRow(1'b1, irSt, 1'b0, 1'b0, '0, "st_clear");
        runRow(1'b0, irSt, 1'b0, 1'b0, '0, "st_rst");
        runRow(1'b0, irSt, 1'b0, 1'b0, F0, "st_t0");
        runRow(1'b0, irSt, 1'b1, 1'b0, F1, "st_t1");
        runRow(1'b0, irSt, 1'b0, 1'b0, F2, "st_t2");
        runRow(1'b0, irSt, 1'b0, 1'b0, B_GRB | B_BAOUT | B_YEN | B_RUN, "st_t3");
        runRow(1'b0, irSt, 1'b0, 1'b0, B_COUT | B_ZLEN | opField(5'h03) | B_RUN, "st_t4");
        runRow(1'b0, irSt, 1'b0, 1'b0, B_ZLOWOUT | B_MAREN | B_RUN, "st_t5");
        runRow(1'b0, irSt, 1'b0, 1'b0, B_GRA | B_ROUT | B_MDREN | B_RUN, "st_t6");
        runRow(1'b0, irSt, 1'b0, 1'b0, B_WRITE | B_RUN, "st_wait");
        runRow(1'b0, irSt, 1'b1, 1'b0, B_WRITE | B_DONE | B_RUN, "st_done");
        runRow(1'b0, irSt, 1'b0, 1'b0, F0, "st_next_t0");
        runRow(1'b0, irSt, 1'b0, 1'b0, F1, "abort_t1");
        runRow(1'b1, irSt, 1'b0, 1'b0, '0, "abort_clear");
        runRow(1'b0, irSt, 1'b0, 1'b0, '0, "abort_rst");
        runRow(1'b0, irSt, 1'b0, 1'b0, F0, "abort_t0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
